// File: rtl/mult_div_unit.sv
// Shared multi-cycle shift/add multiplier and restoring divider producing HI/LO.
// Optional MULT_DIV_EARLY_TERM_EN: multiplies finish early once the remaining multiplier bits are zero.
//
// state   | meaning
// IDLE    | waiting for start; hi/lo hold the last result
// CALC    | one radix-2 iteration per cycle on the magnitudes
// FIXUP   | sign correction, hi/lo written
// DONE    | done pulse (and div_zero for a zero divisor)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t               r_state;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_done;
    logic                 r_div_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_is_div;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_add;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [2*WIDTH-1:0]   w_calc_next;
    logic                 w_calc_last;

    assign w_is_div = op[1];
    assign w_a_neg  = ~op[0] & a[WIDTH-1];
    assign w_b_neg  = ~op[0] & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Multiply: acc = {partial product, unshifted multiplier}, carry lands in the top bit.
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + ({1'b0, r_mcand} & {(WIDTH+1){r_acc[0]}});
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_mcand};
    assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_quo = r_acc[WIDTH-1:0];
    assign w_rem = r_acc[2*WIDTH-1:WIDTH];

`ifdef MULT_DIV_EARLY_TERM_EN
    logic [WIDTH-1:0] w_mask;
    logic             w_early;

    assign w_mask  = ({{(WIDTH-1){1'b0}}, 1'b1} << r_cnt) - {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_early = ~r_is_div && ((r_acc[WIDTH-1:0] & w_mask) == '0);

    // Zero remaining multiplier bits only shift the accumulator; do all of them at once.
    always_comb begin
        w_calc_next = r_is_div ? w_div_next : w_mul_next;
        w_calc_last = (r_cnt == CNT_W'(1));
        if (w_early) begin
            w_calc_next = r_acc >> r_cnt;
            w_calc_last = 1'b1;
        end
    end
`else
    always_comb begin
        w_calc_next = r_is_div ? w_div_next : w_mul_next;
        w_calc_last = (r_cnt == CNT_W'(1));
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (w_is_div && (b == '0)) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_cnt   <= CNT_W'(WIDTH);
                            if (w_is_div) begin
                                r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                                r_mcand <= w_b_mag;
                            end else begin
                                r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                                r_mcand <= w_a_mag;
                            end
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_calc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_calc_last)
                        r_state <= S_FIXUP;
                end
                S_FIXUP: begin
                    if (r_is_div) begin
                        r_lo <= r_neg_q ? -w_quo : w_quo;
                        r_hi <= r_neg_r ? -w_rem : w_rem;
                    end else begin
                        {r_hi, r_lo} <= r_neg_q ? -r_acc : r_acc;
                    end
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_done     <= 1'b0;
                    r_div_zero <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
